charge_pump_multi_fp: RTL and testbench

Multi-channel fixed-point charge pump for the event-driven PLL models. Each channel carries independent UP and DOWN current sources. Each source has a minimum-pulse dead-zone filter and a slew-limited current ramp. Currents are runtime-programmable and are summed into one signed, saturated net output that feeds the loop-filter integrator.

---
 rtl/charge_pump_pkg.sv | 44 ++++
 rtl/cp_source_ramp.sv | 121 ++++++++++++
 rtl/charge_pump_multi_fp.sv | 102 ++++++++++
 tb/tb_charge_pump_multi_fp.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/charge_pump_pkg.sv
// -----------------------------------------------------------------------------
// charge_pump_pkg
// Shared types and helpers for the multi-channel fixed-point charge pump.
//   src_state_e : per-source FSM state encoding
//   DEF_*       : default widths used as parameter defaults
//   wide_t      : full-width signed accumulator type for the net-current sum
//   saturate()  : clips a wide signed value into a signed out_w-bit range
// -----------------------------------------------------------------------------
package charge_pump_pkg;

   typedef enum logic [2:0] {
      SRC_OFF,
      SRC_ARM,
      SRC_RAMP_UP,
      SRC_ON,
      SRC_RAMP_DOWN
   } src_state_e;

   localparam int unsigned DEF_N_CH  = 4;
   localparam int unsigned DEF_CUR_W = 22;
   localparam int unsigned DEF_OUT_W = 24;

   // Wide enough for any sum of N_CH levels of CUR_W bits at practical sizes.
   typedef logic signed [63:0] wide_t;

   // Clip value to [-2^(out_w-1), 2^(out_w-1)-1]; clipped flags that it happened.
   function automatic wide_t saturate(input wide_t value, input int unsigned out_w,
                                      output logic clipped);
      wide_t hi;
      wide_t lo;
      hi      = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
      lo      = -(wide_t'(1) <<< (out_w - 1));
      clipped = 1'b0;
      saturate = value;
      if (value > hi) begin
         saturate = hi;
         clipped  = 1'b1;
      end else if (value < lo) begin
         saturate = lo;
         clipped  = 1'b1;
      end
   endfunction

endpackage

// File: rtl/cp_source_ramp.sv
// -----------------------------------------------------------------------------
// cp_source_ramp
// One charge-pump current source: dead-zone qualifier plus slew-limited ramp.
//   clk, reset : clock, asynchronous active-low reset
//   req        : qualified request (PFD bit AND enable)
//   target     : programmed current level for this source
//   level      : present current level (unsigned, CUR_W bits)
//   is_off     : high while the source FSM is in OFF
// -----------------------------------------------------------------------------
module cp_source_ramp
   import charge_pump_pkg::*;
#(
   parameter int unsigned CUR_W     = DEF_CUR_W,
   parameter int unsigned RAMP_STEP = 512,
   parameter int unsigned MIN_PULSE = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic [CUR_W-1:0] target,
   output logic [CUR_W-1:0] level,
   output logic             is_off
);

   localparam int unsigned      CNT_W    = (MIN_PULSE > 1) ? $clog2(MIN_PULSE + 1) : 1;
   localparam logic [CUR_W-1:0] STEP     = CUR_W'(RAMP_STEP);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_PULSE);

   src_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CUR_W-1:0] level_q, level_d;

   logic [CUR_W:0]   up_sum;
   logic [CUR_W-1:0] ramp_up_lvl;
   logic [CUR_W-1:0] ramp_dn_lvl;

   // One extra bit on the up-step so overshoot past target is detected, not wrapped.
   always_comb begin
      up_sum = {1'b0, level_q} + {1'b0, STEP};
      if (RAMP_STEP == 0 || up_sum >= {1'b0, target}) ramp_up_lvl = target;
      else                                            ramp_up_lvl = up_sum[CUR_W-1:0];
      if (RAMP_STEP == 0 || level_q <= STEP) ramp_dn_lvl = '0;
      else                                   ramp_dn_lvl = level_q - STEP;
   end

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      unique case (state_q)
         SRC_OFF: begin
            if (req) begin
               if (MIN_PULSE <= 1) begin
                  state_d = SRC_RAMP_UP;
               end else begin
                  state_d = SRC_ARM;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         SRC_ARM: begin
            // A pulse shorter than MIN_PULSE is dropped with level still at 0.
            if (!req) begin
               state_d = SRC_OFF;
               cnt_d   = '0;
            end else if (cnt_q + CNT_W'(1) == CNT_LAST) begin
               state_d = SRC_RAMP_UP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SRC_RAMP_UP: begin
            if (!req) begin
               state_d = SRC_RAMP_DOWN;
            end else begin
               level_d = ramp_up_lvl;
               if (ramp_up_lvl == target) state_d = SRC_ON;
            end
         end
         SRC_ON: begin
            if (!req) state_d = SRC_RAMP_DOWN;
            else      level_d = target;
         end
         SRC_RAMP_DOWN: begin
            // Re-assertion resumes ramping up immediately; no requalification.
            if (req) begin
               state_d = SRC_RAMP_UP;
            end else begin
               level_d = ramp_dn_lvl;
               if (ramp_dn_lvl == '0) state_d = SRC_OFF;
            end
         end
         default: begin
            state_d = SRC_OFF;
            cnt_d   = '0;
            level_d = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= SRC_OFF;
         cnt_q   <= '0;
         level_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level  = level_q;
   assign is_off = (state_q == SRC_OFF);

endmodule

// File: rtl/charge_pump_multi_fp.sv
// -----------------------------------------------------------------------------
// charge_pump_multi_fp
// Multi-channel charge pump: 2*N_CH ramped sources summed into one signed,
// saturated, registered net current.
//   clk, reset          : clock, asynchronous active-low reset
//   enable              : low forces every source request low
//   input_up_digital    : per-channel UP requests
//   input_down_digital  : per-channel DOWN requests
//   cfg_valid/cfg_ready : target-current load handshake (ready = all sources OFF)
//   cfg_up_current      : new UP target
//   cfg_down_current    : new DOWN target
//   output_current_real : registered sum(up_level - down_level), saturated
//   output_sat          : registered flag, high when the output was clipped
// -----------------------------------------------------------------------------
module charge_pump_multi_fp
   import charge_pump_pkg::*;
#(
   parameter int unsigned N_CH         = DEF_N_CH,
   parameter int unsigned CUR_W        = DEF_CUR_W,
   parameter int unsigned OUT_W        = DEF_OUT_W,
   parameter int unsigned UP_CURRENT   = 1342,
   parameter int unsigned DOWN_CURRENT = 1342,
   parameter int unsigned RAMP_STEP    = 512,
   parameter int unsigned MIN_PULSE    = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [N_CH-1:0]         input_up_digital,
   input  logic [N_CH-1:0]         input_down_digital,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [CUR_W-1:0]        cfg_up_current,
   input  logic [CUR_W-1:0]        cfg_down_current,
   output logic signed [OUT_W-1:0] output_current_real,
   output logic                    output_sat
);

   logic [CUR_W-1:0]        up_target_q, up_target_d;
   logic [CUR_W-1:0]        down_target_q, down_target_d;
   logic signed [OUT_W-1:0] out_q, out_d;
   logic                    sat_q, sat_d;

   logic [CUR_W-1:0] up_level   [N_CH];
   logic [CUR_W-1:0] down_level [N_CH];
   logic [N_CH-1:0]  up_off;
   logic [N_CH-1:0]  down_off;
   wide_t            sum;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      cp_source_ramp #(
         .CUR_W(CUR_W), .RAMP_STEP(RAMP_STEP), .MIN_PULSE(MIN_PULSE)
      ) u_up (
         .clk(clk), .reset(reset), .req(input_up_digital[i] & enable),
         .target(up_target_q), .level(up_level[i]), .is_off(up_off[i])
      );
      cp_source_ramp #(
         .CUR_W(CUR_W), .RAMP_STEP(RAMP_STEP), .MIN_PULSE(MIN_PULSE)
      ) u_down (
         .clk(clk), .reset(reset), .req(input_down_digital[i] & enable),
         .target(down_target_q), .level(down_level[i]), .is_off(down_off[i])
      );
   end

   // Config is only safe to change when no source is using the targets.
   assign cfg_ready = (&up_off) & (&down_off);

   always_comb begin
      up_target_d   = up_target_q;
      down_target_d = down_target_q;
      if (cfg_valid && cfg_ready) begin
         up_target_d   = cfg_up_current;
         down_target_d = cfg_down_current;
      end
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < N_CH; i++) begin
         sum = sum + wide_t'(up_level[i]) - wide_t'(down_level[i]);
      end
      out_d = OUT_W'(saturate(sum, OUT_W, sat_d));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         up_target_q   <= CUR_W'(UP_CURRENT);
         down_target_q <= CUR_W'(DOWN_CURRENT);
         out_q         <= '0;
         sat_q         <= 1'b0;
      end else begin
         up_target_q   <= up_target_d;
         down_target_q <= down_target_d;
         out_q         <= out_d;
         sat_q         <= sat_d;
      end
   end

   assign output_current_real = out_q;
   assign output_sat          = sat_q;

endmodule

// File: tb/tb_charge_pump_multi_fp.sv
// -----------------------------------------------------------------------------
// tb_charge_pump_multi_fp
// Directed bench. dut_a: N_CH=2, OUT_W=24, RAMP_STEP=512, MIN_PULSE=2.
// dut_b: N_CH=2, OUT_W=12, RAMP_STEP=0, MIN_PULSE=1 (saturation and
// instantaneous-ramp behaviour). Inputs change 1 time unit after a rising
// edge and outputs are read at that same point.
// -----------------------------------------------------------------------------
module tb_charge_pump_multi_fp;

   logic               clk;
   logic               reset;
   logic               enable;
   logic [1:0]         up_a, dn_a, up_b, dn_b;
   logic               cfg_valid;
   logic [21:0]        cfg_up, cfg_dn;
   logic               ready_a, ready_b, sat_a, sat_b;
   logic signed [23:0] out_a;
   logic signed [11:0] out_b;

   int n_checks = 0;
   int n_pass   = 0;

   charge_pump_multi_fp #(
      .N_CH(2), .CUR_W(22), .OUT_W(24), .UP_CURRENT(1342), .DOWN_CURRENT(1342),
      .RAMP_STEP(512), .MIN_PULSE(2)
   ) dut_a (
      .clk(clk), .reset(reset), .enable(enable),
      .input_up_digital(up_a), .input_down_digital(dn_a),
      .cfg_valid(cfg_valid), .cfg_ready(ready_a),
      .cfg_up_current(cfg_up), .cfg_down_current(cfg_dn),
      .output_current_real(out_a), .output_sat(sat_a)
   );

   charge_pump_multi_fp #(
      .N_CH(2), .CUR_W(22), .OUT_W(12), .UP_CURRENT(1342), .DOWN_CURRENT(1342),
      .RAMP_STEP(0), .MIN_PULSE(1)
   ) dut_b (
      .clk(clk), .reset(reset), .enable(enable),
      .input_up_digital(up_b), .input_down_digital(dn_b),
      .cfg_valid(1'b0), .cfg_ready(ready_b),
      .cfg_up_current(cfg_up), .cfg_down_current(cfg_dn),
      .output_current_real(out_b), .output_sat(sat_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b1;
      up_a = '0; dn_a = '0; up_b = '0; dn_b = '0;
      cfg_valid = 1'b0; cfg_up = 22'd0; cfg_dn = 22'd0;
      #2;
      n_checks++;
      if (out_a !== 24'sd0) $display("FAIL reset_out_a: got %0d expected 0", out_a);
      else n_pass++;
      n_checks++;
      if (sat_a !== 1'b0) $display("FAIL reset_sat_a: got %b expected 0", sat_a);
      else n_pass++;
      n_checks++;
      if (ready_a !== 1'b1) $display("FAIL reset_ready_a: got %b expected 1", ready_a);
      else n_pass++;
      n_checks++;
      if (out_b !== 12'sd0) $display("FAIL reset_out_b: got %0d expected 0", out_b);
      else n_pass++;
      tick(2);
      reset = 1'b1;
      tick(1);
   endtask

   task automatic test_single_pulse();
      up_a = 2'b01;
      tick(1);
      n_checks++;
      if (ready_a !== 1'b0) $display("FAIL pulse_arm_ready: got %b expected 0", ready_a);
      else n_pass++;
      up_a = 2'b00;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         n_checks++;
         if (out_a !== 24'sd0) $display("FAIL pulse_out[%0d]: got %0d expected 0", k, out_a);
         else n_pass++;
      end
      n_checks++;
      if (ready_a !== 1'b1) $display("FAIL pulse_idle_ready: got %b expected 1", ready_a);
      else n_pass++;
   endtask

   task automatic test_ramp();
      int exp_out [1:15] = '{0, 0, 0, 512, 1024, 1342, 1342, 1342, 1342, 1342,
                             1342, 1342, 830, 318, 0};
      up_a = 2'b01;
      for (int k = 1; k <= 15; k++) begin
         tick(1);
         n_checks++;
         if (out_a !== 24'(exp_out[k]))
            $display("FAIL ramp_out[%0d]: got %0d expected %0d", k, out_a, exp_out[k]);
         else n_pass++;
         if (k == 13) begin
            n_checks++;
            if (ready_a !== 1'b0) $display("FAIL ramp_ready_busy: got %b expected 0", ready_a);
            else n_pass++;
         end
         if (k == 14) begin
            n_checks++;
            if (ready_a !== 1'b1) $display("FAIL ramp_ready_idle: got %b expected 1", ready_a);
            else n_pass++;
         end
         if (k == 10) up_a = 2'b00;
      end
   endtask

   task automatic test_up_down_cancel();
      up_a = 2'b01; dn_a = 2'b01;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         n_checks++;
         if (out_a !== 24'sd0) $display("FAIL cancel_out[%0d]: got %0d expected 0", k, out_a);
         else n_pass++;
      end
      up_a = 2'b00; dn_a = 2'b00;
      tick(6);
   endtask

   task automatic test_two_channels();
      up_a = 2'b11;
      tick(6);
      n_checks++;
      if (out_a !== 24'sd2684) $display("FAIL two_ch_out: got %0d expected 2684", out_a);
      else n_pass++;
      n_checks++;
      if (sat_a !== 1'b0) $display("FAIL two_ch_sat: got %b expected 0", sat_a);
      else n_pass++;
      up_a = 2'b00;
      tick(6);
   endtask

   task automatic test_enable();
      int exp_out [0:3] = '{1342, 830, 318, 0};
      up_a = 2'b01;
      tick(6);
      n_checks++;
      if (out_a !== 24'sd1342) $display("FAIL enable_on_out: got %0d expected 1342", out_a);
      else n_pass++;
      enable = 1'b0;
      tick(1);
      for (int k = 0; k <= 3; k++) begin
         tick(1);
         n_checks++;
         if (out_a !== 24'(exp_out[k]))
            $display("FAIL enable_off_out[%0d]: got %0d expected %0d", k, out_a, exp_out[k]);
         else n_pass++;
      end
      n_checks++;
      if (ready_a !== 1'b1) $display("FAIL enable_off_ready: got %b expected 1", ready_a);
      else n_pass++;
      up_a = 2'b00; enable = 1'b1;
      tick(2);
   endtask

   task automatic test_saturation();
      up_b = 2'b11;
      tick(2);
      n_checks++;
      if (out_b !== 12'sd0) $display("FAIL sat_up_early: got %0d expected 0", out_b);
      else n_pass++;
      tick(1);
      n_checks++;
      if (out_b !== 12'sd2047) $display("FAIL sat_up_out: got %0d expected 2047", out_b);
      else n_pass++;
      n_checks++;
      if (sat_b !== 1'b1) $display("FAIL sat_up_flag: got %b expected 1", sat_b);
      else n_pass++;
      up_b = 2'b00;
      tick(3);
      n_checks++;
      if (out_b !== 12'sd0 || sat_b !== 1'b0)
         $display("FAIL sat_release: got %0d/%b expected 0/0", out_b, sat_b);
      else n_pass++;
      dn_b = 2'b11;
      tick(3);
      n_checks++;
      if (out_b !== 12'h800) $display("FAIL sat_dn_out: got %0d expected -2048", out_b);
      else n_pass++;
      n_checks++;
      if (sat_b !== 1'b1) $display("FAIL sat_dn_flag: got %b expected 1", sat_b);
      else n_pass++;
      dn_b = 2'b00;
      tick(4);
      up_b = 2'b01;
      tick(3);
      n_checks++;
      if (out_b !== 12'sd1342 || sat_b !== 1'b0)
         $display("FAIL sat_single: got %0d/%b expected 1342/0", out_b, sat_b);
      else n_pass++;
      up_b = 2'b00;
      tick(4);
   endtask

   task automatic test_config();
      int exp_out [1:6] = '{0, 0, 512, 1024, 1536, 2000};
      int budget;
      up_a = 2'b01;
      tick(2);
      cfg_valid = 1'b1; cfg_up = 22'd2000; cfg_dn = 22'd1342;
      n_checks++;
      if (ready_a !== 1'b0) $display("FAIL cfg_busy_ready: got %b expected 0", ready_a);
      else n_pass++;
      tick(4);
      n_checks++;
      if (out_a !== 24'sd1342) $display("FAIL cfg_rejected_out: got %0d expected 1342", out_a);
      else n_pass++;
      cfg_valid = 1'b0; up_a = 2'b00;
      budget = 0;
      while (ready_a !== 1'b1 && budget < 20) begin
         tick(1);
         budget++;
      end
      n_checks++;
      if (ready_a !== 1'b1) $display("FAIL cfg_wait_idle: got %b expected 1", ready_a);
      else n_pass++;
      cfg_valid = 1'b1; up_a = 2'b01;
      tick(1);
      cfg_valid = 1'b0;
      n_checks++;
      if (ready_a !== 1'b0) $display("FAIL cfg_accept_arm: got %b expected 0", ready_a);
      else n_pass++;
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         n_checks++;
         if (out_a !== 24'(exp_out[k]))
            $display("FAIL cfg_ramp_out[%0d]: got %0d expected %0d", k, out_a, exp_out[k]);
         else n_pass++;
      end
      up_a = 2'b00;
      tick(8);
   endtask

   task automatic test_reset_mid_ramp();
      int exp_out [1:6] = '{0, 0, 0, 512, 1024, 1342};
      up_a = 2'b01;
      tick(4);
      n_checks++;
      if (out_a !== 24'sd512) $display("FAIL midramp_pre: got %0d expected 512", out_a);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++;
      if (out_a !== 24'sd0 || sat_a !== 1'b0 || ready_a !== 1'b1)
         $display("FAIL midramp_async: got %0d/%b/%b expected 0/0/1", out_a, sat_a, ready_a);
      else n_pass++;
      #2;
      reset = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         n_checks++;
         if (out_a !== 24'(exp_out[k]))
            $display("FAIL midramp_out[%0d]: got %0d expected %0d", k, out_a, exp_out[k]);
         else n_pass++;
         if (k == 1) begin
            n_checks++;
            if (ready_a !== 1'b0) $display("FAIL midramp_requal: got %b expected 0", ready_a);
            else n_pass++;
         end
      end
      up_a = 2'b00;
      tick(6);
   endtask

   initial begin
      test_reset();
      test_single_pulse();
      test_ramp();
      test_up_down_cancel();
      test_two_channels();
      test_enable();
      test_saturation();
      test_config();
      test_reset_mid_ramp();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
